comparator_search_ctrl: RTL

Sequential successive-approximation controller that drives the `b` operand of the 4-bit magnitude comparator and consumes its three flag outputs. It finds the unknown value on the comparator's `a` inputs by binary search, one probe per clock, and returns that value.

The block sits on the opposite side of the comparator interface: it generates the comparator's inputs and reacts to its outputs. It supports the ALU's compare-based self-test and value-recovery path.

---
 rtl/comparator_search_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/comparator_search_ctrl.sv
// Successive-approximation controller: drives the comparator b operand and recovers a by binary search.
// Optional macro SEARCH_FAULT_CHECK_EN enables flag-consistency checking and the fault output.
module comparator_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             a_greater_than_b,
    input  logic             a_equal_b,
    input  logic             a_less_than_b,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             fault
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] probe_next, result_next;
    logic [WIDTH-1:0] bit_k, bit_below;
    logic [KW-1:0]    k, k_next;
    logic             fault_q, fault_next;
`ifdef SEARCH_FAULT_CHECK_EN
    logic             flags_bad;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            probe   <= '0;
            k       <= '0;
            result  <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_next;
            probe   <= probe_next;
            k       <= k_next;
            result  <= result_next;
            fault_q <= fault_next;
        end
    end

    always_comb begin
        state_next  = state;
        probe_next  = probe;
        k_next      = k;
        result_next = result;
        fault_next  = fault_q;
        bit_k       = WIDTH'(1) << k;
        bit_below   = bit_k >> 1;
`ifdef SEARCH_FAULT_CHECK_EN
        flags_bad   = !$onehot({a_greater_than_b, a_equal_b, a_less_than_b});
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = PROBE;
                    probe_next = WIDTH'(1) << (WIDTH - 1);
                    k_next     = KW'(WIDTH - 1);
                    fault_next = 1'b0;
                end
            end

            PROBE: begin
                // Default is to finish; only a non-final greater/less decision keeps probing.
                state_next = DONE;
                probe_next = '0;
`ifdef SEARCH_FAULT_CHECK_EN
                if (flags_bad) begin
                    result_next = probe;
                    fault_next  = 1'b1;
                end else
`endif
                if (a_equal_b) begin
                    result_next = probe;
                end else if (a_greater_than_b) begin
                    if (k != '0) begin
                        state_next = PROBE;
                        probe_next = probe | bit_below;
                        k_next     = k - 1'b1;
                    end else begin
                        result_next = probe;
`ifdef SEARCH_FAULT_CHECK_EN
                        fault_next  = 1'b1;
`endif
                    end
                end else begin
                    if (k != '0) begin
                        state_next = PROBE;
                        probe_next = (probe & ~bit_k) | bit_below;
                        k_next     = k - 1'b1;
                    end else begin
                        result_next = probe & ~bit_k;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy  = (state == PROBE);
    assign done  = (state == DONE);
    assign fault = fault_q;

endmodule
